// File: rtl/sec32_check_gen_if.sv
`timescale 1ns/1ps
// sec32_check_gen_if
// Groups the data-word input stream, the codeword output stream, the
// test-only injection controls and the handshake counter of sec32_check_gen.
//   master : upstream/downstream environment (drives in_*, inject_*, out_ready)
//   slave  : the check-bit generator itself
//   in_valid/in_ready/in_data/in_chk_en : input word handshake
//   inject_en/inject_pos                : single-bit error injection
//   out_valid/out_ready/out_data/out_check/out_chk_en : codeword handshake
//   word_count                          : completed output handshakes (wraps)
interface sec32_check_gen_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_chk_en;
  logic        inject_en;
  logic [5:0]  inject_pos;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_check;
  logic        out_chk_en;
  logic [15:0] word_count;

  modport master (
    output in_valid, in_data, in_chk_en, inject_en, inject_pos, out_ready,
    input  in_ready, out_valid, out_data, out_check, out_chk_en, word_count
  );

  modport slave (
    input  in_valid, in_data, in_chk_en, inject_en, inject_pos, out_ready,
    output in_ready, out_valid, out_data, out_check, out_chk_en, word_count
  );
endinterface

// File: rtl/sec32_check_gen.sv
`timescale 1ns/1ps
// sec32_check_gen
// Two-stage pipelined check-bit generator for the 32-bit SEC channel.
// S1 captures the word plus nibble/column parity partials; S2 folds the
// partials into the 8 check bits, applies optional single-bit injection to
// the 40-bit {check,data} codeword and holds it for the downstream corrector.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sec32_check_gen_if.slave (input/output handshakes, injection,
//           word_count)
module sec32_check_gen (
  input  logic             clk,
  input  logic             rst_n,
  sec32_check_gen_if.slave bus
);

  // Stage 1 state
  logic        s1_valid_reg;
  logic [31:0] s1_data_reg;
  logic        s1_chk_en_reg;
  logic        s1_inj_en_reg;
  logic [5:0]  s1_inj_pos_reg;
  logic [7:0]  s1_nib_reg;     // parity of nibble k = d[4k+3:4k]
  logic [3:0]  s1_col_lo_reg;  // parity of d[j], d[j+4], d[j+8], d[j+12]
  logic [3:0]  s1_col_hi_reg;  // same columns over the upper half

  // Stage 2 / output state
  logic        s2_valid_reg;
  logic [31:0] out_data_reg;
  logic [7:0]  out_check_reg;
  logic        out_chk_en_reg;
  logic [15:0] word_count_reg;

  logic        in_ready;
  logic        s1_load;
  logic        s2_load;
  logic        out_fire;
  logic [7:0]  nib_next;
  logic [3:0]  col_lo_next;
  logic [3:0]  col_hi_next;
  logic [7:0]  check_next;
  logic [39:0] inj_mask;
  logic [39:0] code_next;

  // Parity partials of the incoming word
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      assign nib_next[gi] = ^bus.in_data[4*gi +: 4];
    end
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign col_lo_next[gi] = bus.in_data[gi]      ^ bus.in_data[gi + 4] ^
                               bus.in_data[gi + 8]  ^ bus.in_data[gi + 12];
      assign col_hi_next[gi] = bus.in_data[gi + 16] ^ bus.in_data[gi + 20] ^
                               bus.in_data[gi + 24] ^ bus.in_data[gi + 28];
    end
  endgenerate

  // Handshake control. in_ready looks through S2 so a full pipe still
  // streams at one word per cycle when downstream is taking data.
  assign s2_load  = s1_valid_reg & (~s2_valid_reg | bus.out_ready);
  assign in_ready = ~s1_valid_reg | s2_load;
  assign s1_load  = bus.in_valid & in_ready;
  assign out_fire = s2_valid_reg & bus.out_ready;

  // check[0..3]: low-half column parity plus a pair of upper nibbles;
  // check[4..7]: a pair of lower nibbles plus upper-half column parity.
  assign check_next[0] = s1_col_lo_reg[0] ^ s1_nib_reg[4] ^ s1_nib_reg[5];
  assign check_next[1] = s1_col_lo_reg[1] ^ s1_nib_reg[6] ^ s1_nib_reg[7];
  assign check_next[2] = s1_col_lo_reg[2] ^ s1_nib_reg[4] ^ s1_nib_reg[6];
  assign check_next[3] = s1_col_lo_reg[3] ^ s1_nib_reg[5] ^ s1_nib_reg[7];
  assign check_next[4] = s1_nib_reg[0] ^ s1_nib_reg[1] ^ s1_col_hi_reg[0];
  assign check_next[5] = s1_nib_reg[2] ^ s1_nib_reg[3] ^ s1_col_hi_reg[1];
  assign check_next[6] = s1_nib_reg[0] ^ s1_nib_reg[2] ^ s1_col_hi_reg[2];
  assign check_next[7] = s1_nib_reg[1] ^ s1_nib_reg[3] ^ s1_col_hi_reg[3];

  // Injection is applied after check generation, so the corrector sees a
  // genuine single-bit error. Positions 40..63 leave the word untouched.
  always_comb begin
    inj_mask = '0;
    if (s1_inj_en_reg && (s1_inj_pos_reg < 6'd40)) begin
      inj_mask = 40'd1 << s1_inj_pos_reg;
    end
  end

  assign code_next = {check_next, s1_data_reg} ^ inj_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_data_reg    <= '0;
      s1_chk_en_reg  <= 1'b0;
      s1_inj_en_reg  <= 1'b0;
      s1_inj_pos_reg <= '0;
      s1_nib_reg     <= '0;
      s1_col_lo_reg  <= '0;
      s1_col_hi_reg  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_reg   <= 1'b1;
        s1_data_reg    <= bus.in_data;
        s1_chk_en_reg  <= bus.in_chk_en;
        s1_inj_en_reg  <= bus.inject_en;
        s1_inj_pos_reg <= bus.inject_pos;
        s1_nib_reg     <= nib_next;
        s1_col_lo_reg  <= col_lo_next;
        s1_col_hi_reg  <= col_hi_next;
      end else if (s2_load) begin
        s1_valid_reg   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg   <= 1'b0;
      out_data_reg   <= '0;
      out_check_reg  <= '0;
      out_chk_en_reg <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid_reg   <= 1'b1;
        out_data_reg   <= code_next[31:0];
        out_check_reg  <= code_next[39:32];
        out_chk_en_reg <= s1_chk_en_reg;
      end else if (out_fire) begin
        s2_valid_reg   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count_reg <= '0;
    end else if (out_fire) begin
      word_count_reg <= word_count_reg + 16'd1;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = s2_valid_reg;
  assign bus.out_data   = out_data_reg;
  assign bus.out_check  = out_check_reg;
  assign bus.out_chk_en = out_chk_en_reg;
  assign bus.word_count = word_count_reg;

endmodule
